// File: rtl/lsu_byte_master.sv
// lsu_byte_master: splits B/H/W loads and stores into little-endian
// byte accesses over a req/ack memory port, with load extension.
module lsu_byte_master #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_ERR,
      S_RESP
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_we;
   logic              r_uns;
   logic              r_err;
   logic [1:0]        r_size;
   logic [1:0]        r_k;
   logic [ADDR_W-1:0] r_addr;
   logic [XLEN-1:0]   r_wdata;
   logic [XLEN-1:0]   r_rbuf;

   logic              w_accept;
   logic              w_bad;
   logic              w_last;
   logic              w_done;
   logic [7:0]        w_byte;
   logic [XLEN-1:0]   w_ext;

   assign w_accept = (r_state == S_IDLE) && req_valid;
   assign w_bad    = (req_size == 2'b11)
                   || ((req_size == 2'b01) && req_addr[0])
                   || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
   assign w_last   = (r_size == 2'b00)
                   || ((r_size == 2'b01) && (r_k == 2'd1))
                   || (r_k == 2'd3);
   assign w_done   = (r_state == S_ACCESS) && mem_ack;
   assign w_byte   = r_wdata[{r_k, 3'b000} +: 8];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:   if (req_valid) w_next = w_bad ? S_ERR : S_ACCESS;
         S_ACCESS: if (mem_ack && w_last) w_next = S_RESP;
         S_ERR:    w_next = S_RESP;
         S_RESP:   w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_we    <= 1'b0;
         r_uns   <= 1'b0;
         r_err   <= 1'b0;
         r_size  <= 2'b00;
         r_k     <= 2'd0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rbuf  <= '0;
      end else if (w_accept) begin
         r_we    <= req_we;
         r_uns   <= req_unsigned;
         r_err   <= w_bad;
         r_size  <= req_size;
         r_k     <= 2'd0;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
         r_rbuf  <= '0;
      end else if (w_done) begin
         if (!r_we) r_rbuf[{r_k, 3'b000} +: 8] <= mem_rdata;
         if (!w_last) r_k <= r_k + 2'd1;
      end
   end

   // Extension is driven from the latched size; W passes through untouched.
   always_comb begin
      w_ext = r_rbuf;
      unique case (r_size)
         2'b00: w_ext = {{(XLEN-8){r_rbuf[7] & ~r_uns}}, r_rbuf[7:0]};
         2'b01: w_ext = {{(XLEN-16){r_rbuf[15] & ~r_uns}}, r_rbuf[15:0]};
         default: w_ext = r_rbuf;
      endcase
   end

   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = 8'h00;
      unique case (r_state)
         S_IDLE: req_ready = 1'b1;
         S_ACCESS: begin
            mem_req   = 1'b1;
            mem_we    = r_we;
            mem_addr  = r_addr + ADDR_W'(r_k);
            mem_wdata = w_byte;
         end
         S_ERR: ;
         S_RESP: begin
            resp_valid = 1'b1;
            resp_err   = r_err;
            if (!r_err && !r_we) resp_rdata = w_ext;
         end
      endcase
   end

endmodule

// File: tb/tb_lsu_byte_master.sv
// tb_lsu_byte_master: directed vectors against a byte memory responder
// with programmable ack delay.
module tb_lsu_byte_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic [7:0]  mem_rdata;

   logic [7:0]  mem [0:255];
   int          delay = 0;
   logic        stray = 1'b0;
   int          cnt = 0;
   int          n_mreq = 0;
   int          n_resp = 0;
   int          n_unst = 0;
   logic        p_wait = 1'b0;
   logic [31:0] p_addr = '0;
   logic        p_we = 1'b0;
   logic [7:0]  p_wd = '0;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   lsu_byte_master dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_err     (resp_err),
      .resp_rdata   (resp_rdata),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata)
   );

   assign mem_ack   = stray | (mem_req && (cnt >= delay));
   assign mem_rdata = mem[mem_addr[7:0]];

   // Responder plus monitors for hold-stability and activity counts.
   always @(posedge clk) begin
      if (mem_req && mem_ack && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      cnt <= (mem_req && !mem_ack) ? cnt + 1 : 0;
      if (mem_req) n_mreq <= n_mreq + 1;
      if (resp_valid) n_resp <= n_resp + 1;
      if (p_wait && (mem_req !== 1'b1 || mem_addr !== p_addr
                     || mem_we !== p_we || mem_wdata !== p_wd))
         n_unst <= n_unst + 1;
      p_wait <= mem_req && !mem_ack;
      p_addr <= mem_addr;
      p_we   <= mem_we;
      p_wd   <= mem_wdata;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input logic we, input logic [1:0] sz,
                      input logic uns, input logic [31:0] a,
                      input logic [31:0] d, output logic err,
                      output logic [31:0] rd, output int cyc);
      chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = a;
      req_wdata    = d;
      tick();
      req_valid = 1'b0;
      cyc = 1;
      while (!resp_valid && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("resp_seen", {31'b0, resp_valid}, 32'd1);
      err = resp_err;
      rd  = resp_rdata;
      tick();
   endtask

   logic        e;
   logic [31:0] r;
   int          c;
   int          m0;
   int          q0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h21] <= 8'h80;
      mem[8'h22] <= 8'h34;
      mem[8'h23] <= 8'hF2;
      rst = 1'b1;
      req_valid = 1'b0;
      req_we = 1'b0;
      req_size = 2'b00;
      req_unsigned = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      tick();
      tick();
      chk("rst_flags", {27'b0, req_ready, mem_req, mem_we, resp_valid, resp_err},
          32'h10);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", {24'b0, mem_wdata}, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      rst = 1'b0;
      tick();

      // SW with zero-wait ack
      m0 = n_mreq;
      run(1'b1, 2'b10, 1'b0, 32'h10, 32'hA1B2C3D4, e, r, c);
      chk("sw_lat", c, 32'd5);
      chk("sw_err", {31'b0, e}, 32'd0);
      chk("sw_rdata", r, 32'h0);
      chk("sw_mreq", n_mreq - m0, 32'd4);
      chk("sw_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]},
          32'hA1B2C3D4);

      // LB / LBU
      run(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, e, r, c);
      chk("lb_rdata", r, 32'hFFFFFF80);
      chk("lb_lat", c, 32'd2);
      run(1'b0, 2'b00, 1'b1, 32'h21, 32'h0, e, r, c);
      chk("lbu_rdata", r, 32'h00000080);

      // LH with two wait cycles per byte
      delay = 2;
      m0 = n_mreq;
      run(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, e, r, c);
      chk("lh_rdata", r, 32'hFFFFF234);
      chk("lh_lat", c, 32'd7);
      chk("lh_mreq", n_mreq - m0, 32'd6);
      chk("lh_stable", n_unst, 32'd0);
      delay = 0;
      run(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, e, r, c);
      chk("lhu_rdata", r, 32'h0000F234);

      // Error cases: no memory traffic
      m0 = n_mreq;
      run(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, e, r, c);
      chk("lw_mis_err", {31'b0, e}, 32'd1);
      chk("lw_mis_rdata", r, 32'h0);
      chk("lw_mis_lat", c, 32'd2);
      run(1'b1, 2'b01, 1'b0, 32'h05, 32'hFFFFFFFF, e, r, c);
      chk("sh_mis_err", {31'b0, e}, 32'd1);
      chk("sh_mis_rdata", r, 32'h0);
      run(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, e, r, c);
      chk("sz11_err", {31'b0, e}, 32'd1);
      chk("sz11_rdata", r, 32'h0);
      chk("err_mreq", n_mreq - m0, 32'd0);

      // Reset during byte 2 of a SW, then stray ack
      q0 = n_resp;
      req_valid = 1'b1;
      req_we = 1'b1;
      req_size = 2'b10;
      req_addr = 32'h40;
      req_wdata = 32'h11223344;
      tick();
      req_valid = 1'b0;
      tick();
      chk("rst_mid_addr", mem_addr, 32'h41);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_mid_mreq", {31'b0, mem_req}, 32'd0);
      stray = 1'b1;
      tick();
      stray = 1'b0;
      chk("stray_ready", {31'b0, req_ready}, 32'd1);
      chk("stray_mreq", {31'b0, mem_req}, 32'd0);
      tick();
      chk("rst_mid_noresp", n_resp - q0, 32'd0);
      run(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, e, r, c);
      chk("lw_after_rst", r, 32'hA1B2C3D4);
      chk("lw_after_lat", c, 32'd5);
      chk("lw_after_err", {31'b0, e}, 32'd0);

      // Back-to-back with req_valid held high
      q0 = n_resp;
      m0 = n_mreq;
      req_valid = 1'b1;
      req_we = 1'b1;
      req_size = 2'b00;
      req_unsigned = 1'b0;
      req_addr = 32'h50;
      req_wdata = 32'h0000005A;
      tick();
      req_we = 1'b0;
      req_unsigned = 1'b1;
      tick();
      chk("b2b_resp1", {30'b0, resp_valid, req_ready}, 32'd2);
      tick();
      chk("b2b_idle", {30'b0, resp_valid, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
      chk("b2b_acc2", {mem_req, mem_we, 22'b0, mem_addr[7:0]},
          32'h80000050);
      tick();
      chk("b2b_resp2", {31'b0, resp_valid}, 32'd1);
      chk("b2b_rdata", resp_rdata, 32'h0000005A);
      tick();
      tick();
      chk("b2b_nresp", n_resp - q0, 32'd2);
      chk("b2b_nmreq", n_mreq - m0, 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
